// File: rtl/ctrl_unit.sv
// ctrl_unit: multi-cycle fetch/decode/sequence controller for the 16-bit mycpu
// datapath. Fetches over a req/ack memory port, drives FU and register-file
// selects, and keeps the Z/N flags used by conditional branches.
//
// Memory handshake: mem_req is raised with mem_addr/mem_we/mem_wdata stable
// and stays high until the rising edge at which mem_ack=1 completes it; an
// ack in the first cycle of a request is legal, an ack with mem_req=0 is
// ignored because no state ever looks at mem_ack outside a requesting state.
module ctrl_unit (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  input  logic [15:0] a_bus,
  input  logic [15:0] b_bus,
  input  logic        z_in,
  input  logic        n_in,
  output logic [3:0]  fs_out,
  output logic [2:0]  sa,
  output logic [2:0]  sb,
  output logic [2:0]  dr,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic [15:0] pc,
  output logic        z_flag,
  output logic        n_flag,
  output logic        halted,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    ST_RST   = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MEM   = 3'd3,
    ST_IMM   = 3'd4,
    ST_HALT  = 3'd5
  } state_t;

  localparam logic [2:0] CL_ALU   = 3'b000;
  localparam logic [2:0] CL_LOAD  = 3'b001;
  localparam logic [2:0] CL_STORE = 3'b010;
  localparam logic [2:0] CL_LDI   = 3'b011;
  localparam logic [2:0] CL_BRZ   = 3'b100;
  localparam logic [2:0] CL_BRN   = 3'b101;
  localparam logic [2:0] CL_JMP   = 3'b110;
  localparam logic [2:0] CL_HALT  = 3'b111;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic        z_q, z_d;
  logic        n_q, n_d;

  logic [2:0]  cls;
  logic [15:0] br_target;

  assign cls       = ir_q[15:13];
  // pc already points past the branch, so the offset is relative to pc+1.
  assign br_target = pc_q + {{7{ir_q[8]}}, ir_q[8:0]};

  assign fs_out    = ir_q[12:9];
  assign dr        = ir_q[8:6];
  assign sa        = ir_q[5:3];
  assign sb        = ir_q[2:0];
  assign pc        = pc_q;
  assign z_flag    = z_q;
  assign n_flag    = n_q;
  assign dbg_state = state_q;

  // State, pc, instruction and flag registers; reset restarts from RST at pc=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RST;
      pc_q    <= '0;
      ir_q    <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      z_q     <= z_d;
      n_q     <= n_d;
    end
  end

  // Next-state and control outputs, decoded from state, ir and mem_ack.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    z_d       = z_q;
    n_d       = n_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    rf_we     = 1'b0;
    wb_sel    = 2'd0;
    halted    = 1'b0;

    unique case (state_q)
      ST_RST: begin
        state_d = ST_FETCH;
      end

      ST_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc_q;
        if (mem_ack) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + 16'd1;
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        state_d = ST_FETCH;
        unique case (cls)
          CL_ALU: begin
            rf_we = 1'b1;
            z_d   = z_in;
            n_d   = n_in;
          end
          CL_LOAD, CL_STORE: state_d = ST_MEM;
          CL_LDI:            state_d = ST_IMM;
          CL_BRZ:            if (z_q) pc_d = br_target;
          CL_BRN:            if (n_q) pc_d = br_target;
          CL_JMP:            pc_d = a_bus;
          CL_HALT:           state_d = ST_HALT;
          default:           state_d = ST_FETCH;
        endcase
      end

      ST_MEM: begin
        mem_req  = 1'b1;
        mem_addr = a_bus;
        if (cls == CL_STORE) begin
          mem_we    = 1'b1;
          mem_wdata = b_bus;
        end
        if (mem_ack) begin
          // Load data is written straight from mem_rdata in the ack cycle.
          if (cls == CL_LOAD) begin
            rf_we  = 1'b1;
            wb_sel = 2'd1;
          end
          state_d = ST_FETCH;
        end
      end

      ST_IMM: begin
        mem_req  = 1'b1;
        mem_addr = pc_q;
        if (mem_ack) begin
          rf_we   = 1'b1;
          wb_sel  = 2'd1;
          pc_d    = pc_q + 16'd1;
          state_d = ST_FETCH;
        end
      end

      ST_HALT: begin
        halted = 1'b1;
      end

      default: begin
        state_d = ST_RST;
      end
    endcase
  end

endmodule

// File: tb/tb_ctrl_unit.sv
// Directed bench for ctrl_unit: a small program in a bench-side memory,
// walked cycle by cycle with hand-computed expectations.
module tb_ctrl_unit;

  localparam logic [2:0] S_RST   = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_MEM   = 3'd3;
  localparam logic [2:0] S_IMM   = 3'd4;
  localparam logic [2:0] S_HALT  = 3'd5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic [15:0] a_bus, b_bus;
  logic        z_in, n_in;
  logic [3:0]  fs_out;
  logic [2:0]  sa, sb, dr;
  logic        rf_we;
  logic [1:0]  wb_sel;
  logic [15:0] pc;
  logic        z_flag, n_flag, halted;
  logic [2:0]  dbg_state;

  int tests_run    = 0;
  int tests_failed = 0;

  // Memory model: combinational ack after ack_delay wait cycles.
  logic [15:0] mem_arr [0:65535];
  int          ack_delay = 0;
  logic [3:0]  wait_cnt  = '0;

  assign mem_ack   = mem_req && (int'(wait_cnt) >= ack_delay);
  assign mem_rdata = mem_arr[mem_addr];

  always @(posedge clk) begin
    if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 4'd1;
    else                     wait_cnt <= '0;
  end

  always #5 clk = ~clk;

  ctrl_unit dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .a_bus(a_bus), .b_bus(b_bus), .z_in(z_in), .n_in(n_in),
    .fs_out(fs_out), .sa(sa), .sb(sb), .dr(dr),
    .rf_we(rf_we), .wb_sel(wb_sel), .pc(pc),
    .z_flag(z_flag), .n_flag(n_flag), .halted(halted),
    .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks that a FETCH is being presented at the given address.
  task automatic expect_fetch(input string tag, input logic [15:0] addr);
    check({tag, "_state"}, 16'(dbg_state), 16'(S_FETCH));
    check({tag, "_addr"}, mem_addr, addr);
    check({tag, "_req"}, 16'(mem_req), 16'd1);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem_arr[i] = 16'h0000;
    // Program
    mem_arr[16'h0000] = 16'h0453; // ALU fs=2 dr=1 sa=2 sb=3
    mem_arr[16'h0001] = 16'h8002; // BRZ +2
    mem_arr[16'h0002] = 16'hE000; // HALT
    mem_arr[16'h0004] = 16'h20E8; // LOAD dr=3 sa=5
    mem_arr[16'h0005] = 16'h400A; // STORE sa=1 sb=2
    mem_arr[16'h0006] = 16'hC000; // JMP
    mem_arr[16'h0010] = 16'h6080; // LDI dr=2
    mem_arr[16'h0011] = 16'h5A5A; // immediate word
    mem_arr[16'h0012] = 16'hC000; // JMP
    mem_arr[16'h001F] = 16'h0200; // ALU fs=1
    mem_arr[16'h0020] = 16'h81FE; // BRZ -2
    mem_arr[16'h0021] = 16'hC000; // JMP
    mem_arr[16'h1234] = 16'hCAFE; // load data
    mem_arr[16'hFFFF] = 16'hA001; // BRN +1

    rst_n = 1'b0; a_bus = '0; b_bus = '0; z_in = 1'b0; n_in = 1'b0;
    tick(); tick();
    check("rst_req", 16'(mem_req), 16'd0);
    check("rst_pc", pc, 16'h0000);
    check("rst_addr", mem_addr, 16'h0000);
    check("rst_fs", 16'(fs_out), 16'd0);
    check("rst_flags", {14'd0, z_flag, n_flag}, 16'd0);
    check("rst_halted", 16'(halted), 16'd0);
    check("rst_rfwe", 16'(rf_we), 16'd0);

    rst_n = 1'b1;                          // cycle 0: RST
    check("c0_state", 16'(dbg_state), 16'(S_RST));
    check("c0_req", 16'(mem_req), 16'd0);
    tick();                                // cycle 1: FETCH @0
    expect_fetch("f0", 16'h0000);
    check("f0_we", 16'(mem_we), 16'd0);
    z_in = 1'b1; n_in = 1'b0;
    tick();                                // EXEC ALU
    check("alu_pc", pc, 16'h0001);
    check("alu_fs", 16'(fs_out), 16'd2);
    check("alu_sel", {4'd0, dr, sa, sb, 3'd0}, {4'd0, 3'd1, 3'd2, 3'd3, 3'd0});
    check("alu_rfwe", 16'(rf_we), 16'd1);
    check("alu_wbsel", 16'(wb_sel), 16'd0);
    tick();                                // FETCH @1
    expect_fetch("f1", 16'h0001);
    check("alu_zflag", 16'(z_flag), 16'd1);
    check("f1_rfwe", 16'(rf_we), 16'd0);
    z_in = 1'b0;
    tick();                                // EXEC BRZ +2, taken
    tick();
    expect_fetch("brz_taken", 16'h0004);
    tick();                                // EXEC LOAD
    a_bus = 16'h1234; ack_delay = 3;
    tick();                                // MEM, 4 cycles
    for (int i = 0; i < 4; i++) begin
      check("ld_state", 16'(dbg_state), 16'(S_MEM));
      check("ld_addr", mem_addr, 16'h1234);
      check("ld_req", 16'(mem_req), 16'd1);
      check("ld_we", 16'(mem_we), 16'd0);
      check("ld_rfwe", 16'(rf_we), (i == 3) ? 16'd1 : 16'd0);
      check("ld_wbsel", 16'(wb_sel), (i == 3) ? 16'd1 : 16'd0);
      tick();
    end
    ack_delay = 0;
    expect_fetch("f5", 16'h0005);
    check("ld_zflag", 16'(z_flag), 16'd1);
    tick();                                // EXEC STORE
    a_bus = 16'h0040; b_bus = 16'hBEEF;
    tick();                                // MEM
    check("st_state", 16'(dbg_state), 16'(S_MEM));
    check("st_we", 16'(mem_we), 16'd1);
    check("st_wdata", mem_wdata, 16'hBEEF);
    check("st_addr", mem_addr, 16'h0040);
    check("st_rfwe", 16'(rf_we), 16'd0);
    tick();
    expect_fetch("f6", 16'h0006);
    check("f6_wdata", mem_wdata, 16'h0000);
    tick();                                // EXEC JMP
    a_bus = 16'h0010;
    tick();
    expect_fetch("jmp10", 16'h0010);
    tick();                                // EXEC LDI
    tick();                                // IMM
    check("imm_state", 16'(dbg_state), 16'(S_IMM));
    check("imm_addr", mem_addr, 16'h0011);
    check("imm_rfwe", 16'(rf_we), 16'd1);
    check("imm_wbsel", 16'(wb_sel), 16'd1);
    tick();
    expect_fetch("f12", 16'h0012);
    check("imm_pc", pc, 16'h0012);
    tick();                                // EXEC JMP
    a_bus = 16'h0020;
    tick();
    expect_fetch("jmp20", 16'h0020);
    check("z_kept", 16'(z_flag), 16'd1);
    tick();                                // EXEC BRZ -2, taken
    tick();
    expect_fetch("brz_back", 16'h001F);
    z_in = 1'b0; n_in = 1'b1;
    tick();                                // EXEC ALU
    tick();
    expect_fetch("f20b", 16'h0020);
    check("zn_flags", {14'd0, z_flag, n_flag}, 16'b01);
    tick();                                // EXEC BRZ, not taken
    tick();
    expect_fetch("brz_nt", 16'h0021);
    tick();                                // EXEC JMP
    a_bus = 16'hFFFF;
    tick();
    expect_fetch("jmpffff", 16'hFFFF);
    tick();                                // EXEC BRN +1
    check("pc_wrap", pc, 16'h0000);
    tick();
    expect_fetch("brn_wrap", 16'h0001);
    tick();                                // EXEC BRZ +2, z=0
    tick();
    expect_fetch("f2", 16'h0002);
    tick();                                // EXEC HALT
    tick();
    for (int i = 0; i < 5; i++) begin
      check("halt_flag", 16'(halted), 16'd1);
      check("halt_req", 16'(mem_req), 16'd0);
      check("halt_rfwe", 16'(rf_we), 16'd0);
      tick();
    end

    // Reset mid-MEM
    mem_arr[16'h0000] = 16'h20E8;         // LOAD
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("r2_state", 16'(dbg_state), 16'(S_RST));
    check("r2_halted", 16'(halted), 16'd0);
    tick();
    expect_fetch("r2_f0", 16'h0000);
    tick();                                // EXEC LOAD
    a_bus = 16'h1234; ack_delay = 10;
    tick();                                // MEM, waiting
    check("r2_memreq", 16'(mem_req), 16'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_req", 16'(mem_req), 16'd0);
    check("async_rfwe", 16'(rf_we), 16'd0);
    ack_delay = 0;
    tick();
    rst_n = 1'b1;
    check("r3_state", 16'(dbg_state), 16'(S_RST));
    tick();
    expect_fetch("r3_f0", 16'h0000);
    check("r3_pc", pc, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
